// File: rtl/decoder_scan_ctrl.sv
// decoder_scan_ctrl: scan sequencer that feeds the sel/en inputs of a 2-to-4 decoder.
// Visits each enabled channel in ascending order and holds it for DWELL_CYCLES cycles.
// It can run one frame or loop frames, and it flags busy and end-of-frame.
// Optional build macro BLANK_GAP_EN: adds one blanking cycle (sel_en=0) at every
// channel boundary. During that cycle sel keeps the old channel, which avoids ghosting.
module decoder_scan_ctrl #(
    parameter int CNT_W        = 8,
    parameter int DWELL_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       continuous,
    input  logic [3:0] chan_mask,
    output logic [1:0] sel,
    output logic       sel_en,
    output logic       busy,
    output logic       frame_done
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DWELL_CYCLES - 1);

`ifdef BLANK_GAP_EN
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DWELL = 2'd1,
        ST_GAP   = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DWELL = 2'd1
    } state_t;
`endif

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       first_chan;
    logic [1:0]       next_chan;
    logic [1:0]       cand;
    logic             found;
    logic             wrap;
`ifdef BLANK_GAP_EN
    logic [1:0]       next_sel;
`endif

    // Lowest enabled channel: this is where a new scan begins.
    always_comb begin
        first_chan = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (chan_mask[i]) begin
                first_chan = 2'(i);
            end
        end
    end

    // Next enabled channel above the current one, wrapping 3 -> 0.
    // Reaching a channel at or below the current one means the frame has ended.
    always_comb begin
        next_chan = sel;
        found     = 1'b0;
        cand      = sel;
        for (int k = 1; k <= 4; k++) begin
            cand = sel + 2'(k);
            if (!found && chan_mask[cand]) begin
                next_chan = cand;
                found     = 1'b1;
            end
        end
        wrap = (next_chan <= sel);
    end

    // Scan state machine. Every output is registered, and stop takes priority over everything except reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            sel        <= 2'd0;
            sel_en     <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
`ifdef BLANK_GAP_EN
            next_sel   <= 2'd0;
`endif
        end else begin
            frame_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (start && !stop && (chan_mask != 4'd0)) begin
                        state  <= ST_DWELL;
                        sel    <= first_chan;
                        sel_en <= 1'b1;
                        busy   <= 1'b1;
                    end
                end

                ST_DWELL: begin
                    if (stop) begin
                        state  <= ST_IDLE;
                        cnt    <= '0;
                        sel_en <= 1'b0;
                        busy   <= 1'b0;
                    end else if (cnt != LAST_CNT) begin
                        cnt <= cnt + CNT_W'(1);
                    end else begin
                        cnt <= '0;
                        if ((chan_mask == 4'd0) || (wrap && !continuous)) begin
                            frame_done <= 1'b1;
                            state      <= ST_IDLE;
                            sel_en     <= 1'b0;
                            busy       <= 1'b0;
                        end else begin
                            frame_done <= wrap;
`ifdef BLANK_GAP_EN
                            state      <= ST_GAP;
                            sel_en     <= 1'b0;
                            next_sel   <= next_chan;
`else
                            sel        <= next_chan;
`endif
                        end
                    end
                end

`ifdef BLANK_GAP_EN
                ST_GAP: begin
                    cnt <= '0;
                    if (stop) begin
                        state  <= ST_IDLE;
                        sel_en <= 1'b0;
                        busy   <= 1'b0;
                    end else begin
                        state  <= ST_DWELL;
                        sel    <= next_sel;
                        sel_en <= 1'b1;
                    end
                end
`endif

                default: begin
                    state  <= ST_IDLE;
                    cnt    <= '0;
                    sel_en <= 1'b0;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule
